alu_issuer: RTL and testbench
=============================

# alu_issuer

Command-side initiator for the combinational `alu` (ops: add, sub, mul, div). It accepts register-addressed commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand and op ports, waits a fixed settle window for the deep combinational mul/div paths, then writes the result back into a local register file and reports it on a response handshake. It sits between the instruction/host side and the `alu` instance at the datapath top.

## Interface
- `DATA_W`, 32, operand/result width (must match `alu`).
- `REG_AW`, 3, register-file address width (8 registers).
- `FIFO_DEPTH`, 4, command FIFO entries (power of two).
- `SETTLE_CYCLES`, 1, cycles operands are held on the ALU before the result is captured (≥1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_op`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  REG_AW  destination and sources.
- `cmd_imm_en`  in  1  when 1, `cmd_imm` replaces rs2 as operand 2.
- `cmd_imm`  in  DATA_W  immediate.
- `host_we`, `host_addr`, `host_wdata`  in  1/REG_AW/DATA_W  register preload port.
- `alu_n1`, `alu_n2`  out  DATA_W  to ALU `n1`/`n2`.
- `alu_op`  out  2  to ALU `op`.
- `alu_res`  in  DATA_W  from ALU `res1`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_rd`  out  REG_AW  destination written.
- `rsp_data`  out  DATA_W  value written.
- `rsp_dz`  out  1  divide-by-zero flag.
- `busy`  out  1  state ≠ IDLE or FIFO not empty.

## Operation
- Commands are pushed when `cmd_valid & cmd_ready`. They are executed strictly in order, one at a time.
- FSM states:
  - **IDLE:** if FIFO not empty, pop the head. Register operands: `alu_n1` = R[rs1]; `alu_n2` = imm_en ? imm : R[rs2]; set `alu_op`. Go to ISSUE with the settle counter loaded to SETTLE_CYCLES-1.
  - **ISSUE:** hold `alu_*` stable. When the counter is 0, capture the result. For op 11 with `alu_n2` == 0, force the result to all-ones and set dz=1; otherwise result = `alu_res` and dz=0. Write R[rd] = result, load rsp_*, go to WB.
  - **WB:** `rsp_valid` = 1, rsp_* held stable. On `rsp_ready`: go to ISSUE with the next command popped if the FIFO is not empty, else go to IDLE.
- Register reads occur at pop. The previous writeback has already completed by then, so no hazard logic is needed.
- Arithmetic is performed entirely by the ALU and is modulo 2^DATA_W. The issuer never widens or sign-extends.
- Host write and writeback to the same register on the same edge: writeback wins and the host write is dropped. Host writes to other registers in the same cycle both take effect.
- Host preload while a command is queued: the operand value is whatever R holds at pop time.
- `cmd_ready` = (count < FIFO_DEPTH), computed from registered count only. Push and pop in the same cycle leave the count unchanged. Push when full is impossible.

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_rd` = 0, `rsp_data` = 0, `rsp_dz` = 0.
  - `alu_n1` = 0, `alu_n2` = 0, `alu_op` = 00, `busy` = 0.
  - All registers = 0, FIFO empty, state IDLE.
- Reset mid-operation aborts the in-flight command, discards queued commands, and cancels any pending write.
- Latency, command accepted at edge k with the FIFO empty and the issuer idle:
  - pop and `alu_*` driven at edge k+1;
  - register write and `rsp_valid` high after edge k+1+SETTLE_CYCLES (k+2 by default).
- Back-to-back throughput is one command per SETTLE_CYCLES+1 cycles when `rsp_ready` is held high.
- `alu_*` are registered outputs and change only at a pop.
- rsp_* change only on entry to WB.

## Structure
- Package `alu_issuer_pkg`:
  - op constants `OP_ADD`=00, `OP_SUB`=01, `OP_MUL`=10, `OP_DIV`=11;
  - state typedef {IDLE, ISSUE, WB};
  - the `DZ_RESULT` all-ones constant.
- Sub-module `cmd_fifo`: synchronous, FIFO_DEPTH × command width, with push/pop/full/empty/count outputs.
- The register file is inline in `alu_issuer`.
- `alu` is instantiated beside `alu_issuer` at the top, not inside it.

## Test plan
- Preload R1=17, R2=21; cmd add rd=3 rs1=1 rs2=2 → rsp_rd=3, rsp_data=38, dz=0 at k+2; R3 reads back 38 as rs1 of the next command.
- R1=55, imm 40, op sub, rd=4 → rsp_data=15. Then R5=7, imm 12, op mul → 84. Then R6=14, imm 3, op div → 4.
- R1=999, imm 0, op div, rd=7 → rsp_dz=1, rsp_data=0xFFFFFFFF, R7=0xFFFFFFFF.
- rsp_ready=0, push 6 commands back-to-back → the 1st is popped and 4 are queued, 5 accepted in total; `cmd_ready` low at the 6th. Release `rsp_ready` → 5 responses arrive in order, 2 cycles apart.
- Host write to R3 on the same edge as a writeback to R3 → R3 holds the ALU result. A host write to R2 on that edge also lands.
- Assert `rst_n`=0 during ISSUE of a mul → all outputs return to reset values immediately, no register written, and after release `busy`=0 with the FIFO empty.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg: op codes, FSM states and constants shared by the ALU issuer
package alu_issuer_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [63:0] DZ_RESULT = '1;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
endpackage

// File: rtl/alu_issuer_if.sv
// alu_issuer_if: command and response handshakes between host and issuer
interface alu_issuer_if #(parameter int DATA_W = 32, parameter int REG_AW = 3);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;
  logic rsp_valid;
  logic rsp_ready;
  logic [REG_AW-1:0] rsp_rd;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_dz;
  modport master(
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, rsp_ready,
    input cmd_ready, rsp_valid, rsp_rd, rsp_data, rsp_dz
  );
  modport slave(
    input cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rd, rsp_data, rsp_dz
  );
endinterface

// File: rtl/alu_issuer_cmd_fifo.sv
// cmd_fifo: show-ahead synchronous FIFO holding packed issuer commands
module cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // storage needs no reset: entries are only read once count covers them
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: queues register-addressed commands, drives the ALU, writes results back
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  alu_issuer_if.slave bus,
  input  logic host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] alu_n1,
  output logic [DATA_W-1:0] alu_n2,
  output logic [1:0] alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic busy
);
  localparam int W = 2 + 3*REG_AW + 1 + DATA_W;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [W-1:0] head;
  logic full, empty, pop, capture, dz;
  logic [FAW:0] count;
  logic [SW-1:0] settle;
  logic [REG_AW-1:0] cur_rd, h_rd, h_rs1, h_rs2;
  logic [1:0] h_op;
  logic h_imm_en;
  logic [DATA_W-1:0] h_imm, result;
  logic [DATA_W-1:0] regs [2**REG_AW];
  cmd_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst_n,
    .push(bus.cmd_valid),
    .pop,
    .din({bus.cmd_op, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_imm_en, bus.cmd_imm}),
    .dout(head),
    .full, .empty, .count
  );
  assign {h_op, h_rd, h_rs1, h_rs2, h_imm_en, h_imm} = head;
  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = state == WB;
  assign busy = state != IDLE || count != '0;
  assign dz = alu_op == OP_DIV && alu_n2 == '0;
  assign result = dz ? DZ_RESULT[DATA_W-1:0] : alu_res;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // sequencing: pop from IDLE or straight out of WB, capture when the settle window ends
  always_comb begin
    state_n = state;
    pop = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : ISSUE;
      end
      ISSUE: begin
        capture = settle == '0;
        state_n = capture ? WB : ISSUE;
      end
      WB: begin
        pop = bus.rsp_ready && !empty;
        state_n = !bus.rsp_ready ? WB : empty ? IDLE : ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end
  // ALU operands latch at pop; response fields latch on entry to WB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_n1 <= '0;
      alu_n2 <= '0;
      alu_op <= OP_ADD;
      cur_rd <= '0;
      settle <= '0;
      bus.rsp_rd <= '0;
      bus.rsp_data <= '0;
      bus.rsp_dz <= 1'b0;
    end else begin
      if (pop) begin
        alu_n1 <= regs[h_rs1];
        alu_n2 <= h_imm_en ? h_imm : regs[h_rs2];
        alu_op <= h_op;
        cur_rd <= h_rd;
        settle <= SW'(SETTLE_CYCLES - 1);
      end else if (state == ISSUE && settle != '0) settle <= settle - SW'(1);
      if (capture) begin
        bus.rsp_rd <= cur_rd;
        bus.rsp_data <= result;
        bus.rsp_dz <= dz;
      end
    end
  // register file: writeback beats a host write to the same register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    else
      for (int i = 0; i < 2**REG_AW; i++)
        if (capture && cur_rd == REG_AW'(i)) regs[i] <= result;
        else if (host_we && host_addr == REG_AW'(i)) regs[i] <= host_wdata;
endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed and random checks of alu_issuer against a sequential model
module tb_alu_issuer;
  import alu_issuer_pkg::*;
  localparam int DW = 32;
  localparam int AW = 3;
  typedef struct packed {logic [AW-1:0] rd; logic [DW-1:0] data; logic dz;} rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] alu_n1, alu_n2, alu_res;
  logic [1:0] alu_op;
  logic busy;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit model_on = 1'b1;
  rsp_t exp_q[$];
  logic [DW-1:0] mregs [8];

  alu_issuer_if #(.DATA_W(DW), .REG_AW(AW)) bus();

  alu_issuer #(.DATA_W(DW), .REG_AW(AW), .FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_op(alu_op), .alu_res(alu_res),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in for the combinational alu; divide by zero returns 0 so the issuer's override shows
  always_comb
    alu_res = alu_op == OP_ADD ? alu_n1 + alu_n2 :
              alu_op == OP_SUB ? alu_n1 - alu_n2 :
              alu_op == OP_MUL ? alu_n1 * alu_n2 :
              alu_n2 == '0 ? '0 : alu_n1 / alu_n2;

  function automatic rsp_t exec(input logic [1:0] op, input logic [AW-1:0] rd, input logic [DW-1:0] a, input logic [DW-1:0] b);
    rsp_t r;
    r.rd = rd;
    r.dz = op == OP_DIV && b == '0;
    case (op)
      OP_ADD: r.data = a + b;
      OP_SUB: r.data = a - b;
      OP_MUL: r.data = a * b;
      default: r.data = r.dz ? {DW{1'b1}} : a / b;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // model: commands execute in order against the registers, as if one at a time
  initial forever begin
    rsp_t r;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      foreach (mregs[i]) mregs[i] = '0;
    end else begin
      cyc++;
      if (model_on) begin
        if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (host_we) mregs[host_addr] = host_wdata;
        if (bus.cmd_valid && bus.cmd_ready) begin
          r = exec(bus.cmd_op, bus.cmd_rd, mregs[bus.cmd_rs1], bus.cmd_imm_en ? bus.cmd_imm : mregs[bus.cmd_rs2]);
          mregs[r.rd] = r.data;
          exp_q.push_back(r);
        end
      end
    end
  end

  // compare: busy tracks outstanding work, every presented response matches the model head
  initial forever begin
    @(negedge clk);
    if (rst_n && model_on) begin
      chk("busy", busy, exp_q.size() != 0);
      if (bus.rsp_valid) begin
        chk("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rsp_rd", bus.rsp_rd, exp_q[0].rd);
          chk("rsp_data", bus.rsp_data, exp_q[0].data);
          chk("rsp_dz", bus.rsp_dz, exp_q[0].dz);
        end
      end
    end
  end

  task automatic hw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input logic ie, input logic [DW-1:0] imm);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_rd = rd;
    bus.cmd_rs1 = rs1;
    bus.cmd_rs2 = rs2;
    bus.cmd_imm_en = ie;
    bus.cmd_imm = imm;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output rsp_t r, output int at);
    int t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_timeout", bus.rsp_valid, 1);
    r = {bus.rsp_rd, bus.rsp_data, bus.rsp_dz};
    at = t;
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                     input logic [AW-1:0] rs2, input logic ie, input logic [DW-1:0] imm,
                     input logic [DW-1:0] ed, input logic edz);
    rsp_t r;
    int at;
    send(op, rd, rs1, rs2, ie, imm);
    get_rsp(r, at);
    chk({name, "_rd"}, r.rd, rd);
    chk({name, "_data"}, r.data, ed);
    chk({name, "_dz"}, r.dz, edz);
    chk({name, "_lat"}, at, 2);
  endtask

  initial begin
    rsp_t r;
    int at, n, last;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_rd = '0;
    bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm = '0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rd", bus.rsp_rd, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_dz", bus.rsp_dz, 0);
    chk("rst_alu_n1", alu_n1, 0);
    chk("rst_alu_n2", alu_n2, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hw(1, 17);
    hw(2, 21);
    run("add", OP_ADD, 3, 1, 2, 0, 0, 38, 0);
    run("r3_back", OP_ADD, 0, 3, 0, 1, 0, 38, 0);
    hw(1, 55);
    run("sub", OP_SUB, 4, 1, 0, 1, 40, 15, 0);
    hw(5, 7);
    run("mul", OP_MUL, 4, 5, 0, 1, 12, 84, 0);
    hw(6, 14);
    run("div", OP_DIV, 4, 6, 0, 1, 3, 4, 0);
    hw(1, 999);
    run("div0", OP_DIV, 7, 1, 0, 1, 0, 32'hFFFF_FFFF, 1);
    run("r7_back", OP_ADD, 0, 7, 0, 1, 0, 32'hFFFF_FFFF, 0);
    // backpressure: five commands fit (one in flight, four queued), the sixth is refused
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_ADD;
      bus.cmd_rd = AW'(i);
      bus.cmd_rs1 = 0;
      bus.cmd_imm_en = 1'b1;
      bus.cmd_imm = DW'(i * 10 + 1);
      chk("bp_ready", bus.cmd_ready, i < 5);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    n = 0;
    last = 0;
    for (int t = 0; t < 40 && n < 5; t++) begin
      if (bus.rsp_valid) begin
        chk("bp_order", bus.rsp_rd, n);
        if (n > 0) chk("bp_gap", cyc - last, 2);
        last = cyc;
        n++;
      end
      @(negedge clk);
    end
    chk("bp_count", n, 5);
    // writeback collisions with host writes; model paused since it has no same-edge notion
    model_on = 1'b0;
    hw(1, 100);
    send(OP_ADD, 3, 1, 0, 1, 5);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = 3;
    host_wdata = 777;
    @(negedge clk);
    host_we = 1'b0;
    get_rsp(r, at);
    chk("col_rsp", r.data, 105);
    run("col_r3", OP_ADD, 0, 3, 0, 1, 0, 105, 0);
    send(OP_ADD, 3, 1, 0, 1, 6);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = 2;
    host_wdata = 4242;
    @(negedge clk);
    host_we = 1'b0;
    get_rsp(r, at);
    chk("col2_rsp", r.data, 106);
    run("col2_r2", OP_ADD, 0, 2, 0, 1, 0, 4242, 0);
    run("col2_r3", OP_ADD, 0, 3, 0, 1, 0, 106, 0);
    // reset in the middle of a multiply
    send(OP_MUL, 5, 1, 1, 0, 0);
    @(negedge clk);
    chk("mid_op", alu_op, OP_MUL);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_cmd_ready", bus.cmd_ready, 1);
    chk("mr_alu_n1", alu_n1, 0);
    chk("mr_alu_op", alu_op, 0);
    chk("mr_rsp_data", bus.rsp_data, 0);
    chk("mr_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
    @(negedge clk);
    chk("mr_busy_after", busy, 0);
    run("mr_r5", OP_ADD, 0, 5, 0, 1, 0, 0, 0);
    run("mr_r1", OP_ADD, 0, 1, 0, 1, 0, 0, 0);
    // random traffic; host writes only when nothing is outstanding
    for (int i = 0; i < 600; i++) begin
      bus.rsp_ready = ($urandom % 4) != 0;
      bus.cmd_valid = ($urandom % 3) == 0;
      bus.cmd_op = 2'($urandom);
      bus.cmd_rd = AW'($urandom);
      bus.cmd_rs1 = AW'($urandom);
      bus.cmd_rs2 = AW'($urandom);
      bus.cmd_imm_en = 1'($urandom);
      bus.cmd_imm = ($urandom % 4) == 0 ? '0 : ($urandom % 2) ? DW'($urandom % 20) : DW'($urandom);
      host_we = exp_q.size() == 0 && !bus.cmd_valid && ($urandom % 2) == 1;
      host_addr = AW'($urandom);
      host_wdata = ($urandom % 2) ? DW'($urandom % 50) : DW'($urandom);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    host_we = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
